// File: rtl/joy_pkg.sv
// Shared definitions for the joystick conditioning path: DCBAUDLR bit
// positions, CPC matrix row bit positions, autofire phase type and the
// helpers that turn a cleaned joystick byte into a matrix row byte.
package joy_pkg;

  // Raw / clean joystick byte layout (active-low): --DCBAUDLR
  localparam int unsigned JOY_RIGHT = 0;
  localparam int unsigned JOY_LEFT  = 1;
  localparam int unsigned JOY_DOWN  = 2;
  localparam int unsigned JOY_UP    = 3;
  localparam int unsigned JOY_FIRE1 = 4;
  localparam int unsigned JOY_FIRE2 = 5;

  // Number of meaningful bits per joystick
  localparam int unsigned JOY_BITS = 6;

  // CPC keyboard matrix row layout (active-low)
  localparam int unsigned ROW_UP    = 0;
  localparam int unsigned ROW_DOWN  = 1;
  localparam int unsigned ROW_LEFT  = 2;
  localparam int unsigned ROW_RIGHT = 3;
  localparam int unsigned ROW_FIRE2 = 4;
  localparam int unsigned ROW_FIRE1 = 5;

  localparam logic [7:0] JOY_RELEASED = 8'hFF;

  // Autofire phase: which half of the autofire period the held button is in
  typedef enum logic {
    PHASE_PRESSED  = 1'b0,
    PHASE_RELEASED = 1'b1
  } af_phase_t;

  // Opposing directions pressed together cancel each other out
  function automatic logic [7:0] socd_clean(input logic [7:0] j);
    logic [7:0] r;
    r = j;
    if (!j[JOY_UP] && !j[JOY_DOWN]) begin
      r[JOY_UP]   = 1'b1;
      r[JOY_DOWN] = 1'b1;
    end
    if (!j[JOY_LEFT] && !j[JOY_RIGHT]) begin
      r[JOY_LEFT]  = 1'b1;
      r[JOY_RIGHT] = 1'b1;
    end
    return r;
  endfunction

  // Reorder a DCBAUDLR byte into the CPC matrix row bit order
  function automatic logic [7:0] joy_to_row(input logic [7:0] j);
    logic [7:0] r;
    r            = JOY_RELEASED;
    r[ROW_UP]    = j[JOY_UP];
    r[ROW_DOWN]  = j[JOY_DOWN];
    r[ROW_LEFT]  = j[JOY_LEFT];
    r[ROW_RIGHT] = j[JOY_RIGHT];
    r[ROW_FIRE2] = j[JOY_FIRE2];
    r[ROW_FIRE1] = j[JOY_FIRE1];
    return r;
  endfunction

  // Next autofire phase when the half-period expires
  function automatic af_phase_t phase_flip(input af_phase_t p);
    return (p == PHASE_PRESSED) ? PHASE_RELEASED : PHASE_PRESSED;
  endfunction

endpackage

// File: rtl/joy_debounce.sv
// Single-bit input conditioner: 2-flop synchroniser followed by a
// consecutive-cycle debounce counter. Idle/reset level is 1 (released).
module joy_debounce
  import joy_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button level into the clk domain
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // Flip the clean level only after DEBOUNCE_CYCLES consecutive differing cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      dout <= 1'b1;
    end else if (sync2 == dout) begin
      cnt <= '0;
    end else if (cnt == DB_LAST) begin
      cnt  <= '0;
      dout <= ~dout;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/joy_conditioner.sv
// Joystick conditioner: debounces both raw joystick bytes, removes
// impossible direction pairs, applies optional autofire on Fire 1 and
// drives the registered CPC matrix rows 9 and 6 plus a change strobe.
module joy_conditioner
  import joy_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned AUTOFIRE_DIV    = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] joystick1,
  input  logic [7:0] joystick2,
  input  logic [1:0] autofire_en,
  output logic [7:0] joy1_clean,
  output logic [7:0] joy2_clean,
  output logic [7:0] row9_n,
  output logic [7:0] row6_n,
  output logic       changed
);

  localparam int unsigned NDB  = 2 * JOY_BITS;
  localparam int unsigned AF_W = $clog2(AUTOFIRE_DIV) + 1;
  localparam logic [AF_W-1:0] AF_LAST = AF_W'(AUTOFIRE_DIV - 1);

  logic [NDB-1:0] raw_bits;
  logic [NDB-1:0] clean_bits;
  logic [1:0]     fire1_mat;
  logic [7:0]     eff1;
  logic [7:0]     eff2;
  logic [7:0]     row9_next;
  logic [7:0]     row6_next;
  logic           unused_hi_bits;

  // Bits 7:6 of the raw bytes carry nothing
  assign unused_hi_bits = ^{joystick1[7:6], joystick2[7:6]};

  assign raw_bits = {joystick2[JOY_BITS-1:0], joystick1[JOY_BITS-1:0]};

  genvar gi;
  for (gi = 0; gi < NDB; gi++) begin : g_db
    joy_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .din  (raw_bits[gi]),
      .dout (clean_bits[gi])
    );
  end

  assign joy1_clean = {2'b11, clean_bits[JOY_BITS-1:0]};
  assign joy2_clean = {2'b11, clean_bits[NDB-1:JOY_BITS]};

  // Autofire: identical per-joystick logic. The counter and phase are
  // reset whenever Fire 1 is released, so a new press always starts in the
  // pressed phase with a zero count; no separate press-edge detector needed.
  genvar gj;
  for (gj = 0; gj < 2; gj++) begin : g_af
    logic            clean_fire1;
    logic [AF_W-1:0] cnt;
    af_phase_t       phase;

    assign clean_fire1 = clean_bits[gj*JOY_BITS + JOY_FIRE1];

    // Count held cycles and toggle the phase every AUTOFIRE_DIV of them
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt   <= '0;
        phase <= PHASE_PRESSED;
      end else if (clean_fire1) begin
        cnt   <= '0;
        phase <= PHASE_PRESSED;
      end else if (cnt == AF_LAST) begin
        cnt   <= '0;
        phase <= phase_flip(phase);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    // Enable only gates the output; the counter keeps running underneath
    assign fire1_mat[gj] = autofire_en[gj]
                         ? (clean_fire1 | (phase == PHASE_RELEASED))
                         : clean_fire1;
  end

  // Matrix-path bytes: clean values with SOCD cleaning and autofired Fire 1
  always_comb begin
    eff1            = socd_clean(joy1_clean);
    eff2            = socd_clean(joy2_clean);
    eff1[JOY_FIRE1] = fire1_mat[0];
    eff2[JOY_FIRE1] = fire1_mat[1];
    row9_next       = joy_to_row(eff1);
    row6_next       = joy_to_row(eff2);
  end

  // Register the matrix rows and flag any cycle in which either row moves
  always_ff @(posedge clk) begin
    if (reset) begin
      row9_n  <= JOY_RELEASED;
      row6_n  <= JOY_RELEASED;
      changed <= 1'b0;
    end else begin
      row9_n  <= row9_next;
      row6_n  <= row6_next;
      changed <= (row9_next != row9_n) || (row6_next != row6_n);
    end
  end

endmodule

// File: tb/tb_joy_conditioner.sv
// Bench for joy_conditioner: directed scenarios with literal expectations
// plus randomized stimulus, all checked every cycle against a behavioural
// model built from sample history and held-time arithmetic.
module tb_joy_conditioner;

  localparam int DEB = 4;
  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] joystick1;
  logic [7:0] joystick2;
  logic [1:0] autofire_en;
  logic [7:0] joy1_clean;
  logic [7:0] joy2_clean;
  logic [7:0] row9_n;
  logic [7:0] row6_n;
  logic       changed;

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;

  always #5 clk = ~clk;

  joy_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .AUTOFIRE_DIV   (DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .autofire_en(autofire_en),
    .joy1_clean (joy1_clean),
    .joy2_clean (joy2_clean),
    .row9_n     (row9_n),
    .row6_n     (row6_n),
    .changed    (changed)
  );

  // ---------------- behavioural model ----------------
  // hist[j][k] = raw bits sampled k edges ago (k=0 is this edge)
  logic [5:0] m_hist [2][0:DEB+1];
  logic [5:0] m_clean [2];
  int         m_held [2];
  logic [7:0] m_row [2];
  logic       m_changed;
  bit         model_valid = 0;

  function automatic logic [7:0] model_row(input logic [5:0] c, input int held, input logic en);
    bit up, dn, lf, rt, f1, f2;
    up = !c[3]; dn = !c[2]; lf = !c[1]; rt = !c[0]; f2 = !c[5];
    if (up && dn) begin up = 0; dn = 0; end
    if (lf && rt) begin lf = 0; rt = 0; end
    if (c[4])    f1 = 0;
    else if (en) f1 = ((held / DIV) % 2) == 0;
    else         f1 = 1;
    return {2'b11, !f1, !f2, !rt, !lf, !dn, !up};
  endfunction

  task automatic model_step();
    logic [7:0] nr [2];
    logic [5:0] raw [2];
    bit all_diff;
    raw[0] = joystick1[5:0];
    raw[1] = joystick2[5:0];
    if (reset) begin
      for (int j = 0; j < 2; j++) begin
        for (int k = 0; k <= DEB + 1; k++) m_hist[j][k] = 6'h3F;
        m_clean[j] = 6'h3F;
        m_held[j]  = 0;
        m_row[j]   = 8'hFF;
      end
      m_changed   = 1'b0;
      model_valid = 1;
    end else begin
      for (int j = 0; j < 2; j++) nr[j] = model_row(m_clean[j], m_held[j], autofire_en[j]);
      m_changed = (nr[0] != m_row[0]) || (nr[1] != m_row[1]);
      for (int j = 0; j < 2; j++) begin
        m_row[j]  = nr[j];
        m_held[j] = m_clean[j][4] ? 0 : m_held[j] + 1;
        for (int k = DEB + 1; k > 0; k--) m_hist[j][k] = m_hist[j][k-1];
        m_hist[j][0] = raw[j];
        // a bit flips when the last DEB synchronised samples all disagree with it
        for (int b = 0; b < 6; b++) begin
          all_diff = 1;
          for (int k = 2; k <= DEB + 1; k++)
            if (m_hist[j][k][b] == m_clean[j][b]) all_diff = 0;
          if (all_diff) m_clean[j][b] = ~m_clean[j][b];
        end
      end
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_valid) begin
      vectors++;
      if (joy1_clean !== {2'b11, m_clean[0]}) begin
        miscompares++;
        $display("FAIL joy1_clean t=%0t got=%h exp=%h", $time, joy1_clean, {2'b11, m_clean[0]});
      end
      if (joy2_clean !== {2'b11, m_clean[1]}) begin
        miscompares++;
        $display("FAIL joy2_clean t=%0t got=%h exp=%h", $time, joy2_clean, {2'b11, m_clean[1]});
      end
      if (row9_n !== m_row[0]) begin
        miscompares++;
        $display("FAIL row9_n t=%0t got=%h exp=%h", $time, row9_n, m_row[0]);
      end
      if (row6_n !== m_row[1]) begin
        miscompares++;
        $display("FAIL row6_n t=%0t got=%h exp=%h", $time, row6_n, m_row[1]);
      end
      if (changed !== m_changed) begin
        miscompares++;
        $display("FAIL changed t=%0t got=%b exp=%b", $time, changed, m_changed);
      end
      if (changed === 1'b1) pulses++;
    end
  end

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #2;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic b5;
    int   hold;
    reset       = 1'b1;
    joystick1   = 8'hFF;
    joystick2   = 8'hFF;
    autofire_en = 2'b00;
    step(3);
    reset = 1'b0;
    chk("rst_row9", row9_n, 8'hFF);
    chk("rst_row6", row6_n, 8'hFF);
    chk("rst_joy1", joy1_clean, 8'hFF);
    chk("rst_changed", changed, 0);

    // idle
    pulses = 0;
    step(10);
    chk("idle_pulses", pulses, 0);
    chk("idle_row9", row9_n, 8'hFF);

    // up held on joystick 0
    joystick1 = 8'hF7;
    pulses    = 0;
    step(5);
    chk("up_clean_early", joy1_clean, 8'hFF);
    step(1);
    chk("up_clean", joy1_clean, 8'hF7);
    chk("up_row9_early", row9_n, 8'hFF);
    step(1);
    chk("up_row9", row9_n, 8'hFE);
    step(3);
    chk("up_pulses", pulses, 1);
    joystick1 = 8'hFF;
    step(10);

    // 3-cycle glitch on right
    pulses    = 0;
    joystick1 = 8'hFE;
    step(3);
    joystick1 = 8'hFF;
    step(10);
    chk("glitch_pulses", pulses, 0);
    chk("glitch_joy1", joy1_clean, 8'hFF);
    chk("glitch_row9", row9_n, 8'hFF);

    // up+down on joystick 1
    pulses    = 0;
    joystick2 = 8'hF3;
    step(8);
    chk("socd_joy2", joy2_clean, 8'hF3);
    chk("socd_row6", row6_n, 8'hFF);
    chk("socd_pulses", pulses, 0);
    joystick2 = 8'hFF;
    step(10);

    // autofire on joystick 0
    autofire_en = 2'b01;
    joystick1   = 8'hEF;
    step(6);
    chk("af_clean", joy1_clean, 8'hEF);
    for (int s = 1; s <= 32; s++) begin
      step(1);
      b5 = row9_n[5];
      chk($sformatf("af_fire1_%0d", s), b5, (((s - 1) / 8) % 2 == 0) ? 0 : 1);
    end
    joystick1   = 8'hFF;
    autofire_en = 2'b00;
    step(10);

    // reset during a debounce
    joystick2 = 8'hFE;
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(5);
    chk("rstmid_joy2_early", joy2_clean, 8'hFF);
    step(1);
    chk("rstmid_joy2", joy2_clean, 8'hFE);
    step(1);
    chk("rstmid_row6", row6_n, 8'hF7);
    joystick2 = 8'hFF;
    step(10);

    // randomized segments
    for (int seg = 0; seg < 300; seg++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        step($urandom_range(1, 3));
        reset = 1'b0;
      end
      if ($urandom_range(0, 2) != 0) joystick1 = 8'($urandom);
      if ($urandom_range(0, 2) != 0) joystick2 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) autofire_en = 2'($urandom);
      hold = $urandom_range(1, 14);
      step(hold);
    end
    joystick1 = 8'hFF;
    joystick2 = 8'hFF;
    step(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
